// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - operand/result handshake bundle for serial_subtractor
// SERIAL_SUB_SIGNED_OVF_EN adds the overflow signal to the bundle.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] difference;
  logic             borrow_out;
  logic             busy;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic             overflow;

  modport master (
    output in_valid, a, b, borrow_in, out_ready,
    input  in_ready, out_valid, difference, borrow_out, busy, overflow
  );
  modport slave (
    input  in_valid, a, b, borrow_in, out_ready,
    output in_ready, out_valid, difference, borrow_out, busy, overflow
  );
`else
  modport master (
    output in_valid, a, b, borrow_in, out_ready,
    input  in_ready, out_valid, difference, borrow_out, busy
  );
  modport slave (
    input  in_valid, a, b, borrow_in, out_ready,
    output in_ready, out_valid, difference, borrow_out, busy
  );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - LSB-first multi-cycle subtractor, BITS_PER_CYCLE bits per clock
// SERIAL_SUB_SIGNED_OVF_EN adds a two's-complement overflow flag valid with out_valid.
module serial_subtractor #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  serial_subtractor_if.slave bus
);
  localparam int BPC   = BITS_PER_CYCLE;
  localparam int STEPS = WIDTH / BPC;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  generate
    if ((WIDTH < 2) || ((WIDTH % BPC) != 0)) begin : g_bad_cfg
      $error("serial_subtractor: BITS_PER_CYCLE must divide WIDTH and WIDTH must be >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state;
  state_t               state_nx;
  logic [WIDTH-1:0]     a_sh;
  logic [WIDTH-1:0]     b_sh;
  logic [WIDTH-1:0]     res_sh;
  logic                 br_q;
  logic                 br_next;
  logic [CW-1:0]        cnt;
  logic [BPC-1:0]       d_bits;
  logic [WIDTH+BPC-1:0] res_cat;
  logic                 accept;
  logic                 last_step;

  assign accept    = bus.in_valid & bus.in_ready;
  assign last_step = (cnt == CW'(STEPS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (last_step) state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = accept ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // in_ready is gated by rst so nothing is taken while reset is asserted.
  always_comb begin
    bus.in_ready  = ~rst & ((state == IDLE) | ((state == DONE) & bus.out_ready));
    bus.out_valid = (state == DONE);
    bus.busy      = (state == RUN);
  end

  // Ripple-borrow across the BPC low bits, then the new bits enter the result from the top.
  always_comb begin
    logic br;
    d_bits = '0;
    br     = br_q;
    for (int i = 0; i < BPC; i++) begin
      d_bits[i] = a_sh[i] ^ b_sh[i] ^ br;
      br        = (~a_sh[i] & b_sh[i]) | (~(a_sh[i] ^ b_sh[i]) & br);
    end
    br_next = br;
    res_cat = {d_bits, res_sh} >> BPC;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      br_q   <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sh <= bus.a;
      b_sh <= bus.b;
      br_q <= bus.borrow_in;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> BPC;
      b_sh   <= b_sh >> BPC;
      res_sh <= res_cat[WIDTH-1:0];
      br_q   <= br_next;
      if (!last_step) cnt <= cnt + 1'b1;
    end
  end

  assign bus.difference = res_sh;
  assign bus.borrow_out = br_q;

`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic a_msb;
  logic b_msb;
  logic ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      a_msb <= bus.a[WIDTH-1];
      b_msb <= bus.b[WIDTH-1];
    end else if ((state == RUN) && last_step) begin
      ovf_q <= (a_msb ^ b_msb) & (a_msb ^ d_bits[BPC-1]);
    end
  end

  assign bus.overflow = ovf_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed and randomized checks of serial_subtractor
// Overflow checks are compiled in when SERIAL_SUB_SIGNED_OVF_EN is defined.
module tb_serial_subtractor;
  logic clk;
  logic rst_d;
  logic rst_r;
  logic go;
  int   checks;
  int   failures;
  int   done_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Directed instances share one set of drivers; sel4 picks which one is observed.
  logic       dv, dr, dbin, sel4;
  logic [7:0] da, db;

  serial_subtractor_if #(.WIDTH(8)) d1_if ();
  serial_subtractor_if #(.WIDTH(8)) d4_if ();

  serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_d1 (.clk(clk), .rst(rst_d), .bus(d1_if));
  serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_d4 (.clk(clk), .rst(rst_d), .bus(d4_if));

  assign d1_if.in_valid  = dv;
  assign d1_if.a         = da;
  assign d1_if.b         = db;
  assign d1_if.borrow_in = dbin;
  assign d1_if.out_ready = dr;
  assign d4_if.in_valid  = dv;
  assign d4_if.a         = da;
  assign d4_if.b         = db;
  assign d4_if.borrow_in = dbin;
  assign d4_if.out_ready = dr;

  logic       o_valid, o_ready, o_bout, o_busy;
  logic [7:0] o_diff;
  assign o_valid = sel4 ? d4_if.out_valid  : d1_if.out_valid;
  assign o_ready = sel4 ? d4_if.in_ready   : d1_if.in_ready;
  assign o_bout  = sel4 ? d4_if.borrow_out : d1_if.borrow_out;
  assign o_busy  = sel4 ? d4_if.busy       : d1_if.busy;
  assign o_diff  = sel4 ? d4_if.difference : d1_if.difference;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic o_ovf;
  assign o_ovf = sel4 ? d4_if.overflow : d1_if.overflow;
`endif

  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic bin);
    @(negedge clk);
    dv = 1'b1; da = a; db = b; dbin = bin;
    @(posedge clk);
    #1;
    dv = 1'b0; da = 8'($urandom); db = 8'($urandom); dbin = 1'($urandom);
  endtask

  task automatic wait_result(output int n);
    n = 0;
    while (!o_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic retire();
    @(negedge clk);
    dr = 1'b1;
    @(posedge clk);
    #1;
    dr = 1'b0;
    check("retire_ov", 32'(o_valid), 0);
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bin,
                        input logic [7:0] ed, input logic eb, input int lat, input logic eovf);
    int n;
    start_op(a, b, bin);
    wait_result(n);
    check({tag, "_lat"}, n, lat);
    check({tag, "_diff"}, 32'(o_diff), 32'(ed));
    check({tag, "_bout"}, 32'(o_bout), 32'(eb));
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    check({tag, "_ovf"}, 32'(o_ovf), 32'(eovf));
`else
    if (eovf === 1'bx) check({tag, "_ovf_arg"}, 32'(eovf), 0);
`endif
    retire();
  endtask

  initial begin : main
    int n;
    int t;
    logic any_ov;
    checks = 0; failures = 0; done_cnt = 0; go = 1'b0;
    dv = 1'b0; dr = 1'b0; dbin = 1'b0; da = '0; db = '0; sel4 = 1'b0;
    rst_d = 1'b1; rst_r = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(o_ready), 0);
    check("rst_out_valid", 32'(o_valid), 0);
    check("rst_diff", 32'(o_diff), 0);
    check("rst_bout", 32'(o_bout), 0);
    check("rst_busy", 32'(o_busy), 0);
    rst_d = 1'b0; rst_r = 1'b0;
    #1;
    check("idle_in_ready", 32'(o_ready), 1);

    run_op("t05_03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 8, 1'b0);
    run_op("t03_05", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 8, 1'b0);
    run_op("t00_00b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 8, 1'b0);

    // Stall in DONE, then retire and accept on the same edge.
    start_op(8'h40, 8'h01, 1'b0);
    check("run_busy", 32'(o_busy), 1);
    wait_result(n);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("stall_ov", 32'(o_valid), 1);
      check("stall_diff", 32'(o_diff), 32'h3F);
      check("stall_bout", 32'(o_bout), 0);
    end
    @(negedge clk);
    dr = 1'b1; dv = 1'b1; da = 8'h10; db = 8'h01; dbin = 1'b0;
    #1;
    check("b2b_ready", 32'(o_ready), 1);
    @(posedge clk);
    #1;
    dr = 1'b0; dv = 1'b0;
    check("b2b_ov_low", 32'(o_valid), 0);
    check("b2b_busy", 32'(o_busy), 1);
    wait_result(n);
    check("b2b_lat", n, 8);
    check("b2b_diff", 32'(o_diff), 32'h0F);
    check("b2b_bout", 32'(o_bout), 0);
    retire();

    // Reset in the middle of a run abandons it.
    start_op(8'hAA, 8'h55, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("mid_busy", 32'(o_busy), 1);
    rst_d = 1'b1;
    #1;
    check("mrst_diff", 32'(o_diff), 0);
    check("mrst_bout", 32'(o_bout), 0);
    check("mrst_ov", 32'(o_valid), 0);
    check("mrst_busy", 32'(o_busy), 0);
    check("mrst_ready", 32'(o_ready), 0);
    @(negedge clk);
    rst_d = 1'b0;
    any_ov = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (o_valid) any_ov = 1'b1;
    end
    check("mrst_no_ov", 32'(any_ov), 0);
    run_op("t20_10", 8'h20, 8'h10, 1'b0, 8'h10, 1'b0, 8, 1'b0);

    sel4 = 1'b1;
    run_op("p4_80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 2, 1'b1);
    run_op("p4_7f_01", 8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 2, 1'b0);

    go = 1'b1;
    t = 0;
    while (done_cnt < 6 && t < 40000) begin
      @(posedge clk);
      t++;
    end
    check("rnd_complete", done_cnt, 6);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  localparam int NOPS = 200;

  for (genvar g = 0; g < 6; g++) begin : g_rnd
    localparam int W     = (g < 3) ? 8 : 16;
    localparam int P     = (g % 3 == 0) ? 1 : ((g % 3 == 1) ? 2 : 4);
    localparam int STEPS = W / P;

    serial_subtractor_if #(.WIDTH(W)) rif ();
    serial_subtractor #(.WIDTH(W), .BITS_PER_CYCLE(P)) u_dut (.clk(clk), .rst(rst_r), .bus(rif));

    int         iter, acc_iter, done_ops;
    logic       pending, exp_ov, mrdy, ebo, eovf;
    logic [W-1:0] ed;
    logic [W:0] full;

    initial begin
      rif.in_valid = 1'b0; rif.out_ready = 1'b0; rif.a = '0; rif.b = '0; rif.borrow_in = 1'b0;
      pending = 1'b0; iter = 0; acc_iter = 0; done_ops = 0;
      wait (go);
      while (done_ops < NOPS && iter < 15000) begin
        @(negedge clk);
        rif.in_valid  = ($urandom % 4) != 0;
        rif.out_ready = ($urandom % 3) != 0;
        rif.a         = W'($urandom);
        rif.b         = W'($urandom);
        rif.borrow_in = 1'($urandom);
        #1;
        exp_ov = pending && (iter >= acc_iter + STEPS + 1);
        mrdy   = !pending || (exp_ov && rif.out_ready);
        check($sformatf("r%0d_ov", g), 32'(rif.out_valid), 32'(exp_ov));
        check($sformatf("r%0d_rdy", g), 32'(rif.in_ready), 32'(mrdy));
        check($sformatf("r%0d_busy", g), 32'(rif.busy), 32'(pending && !exp_ov));
        if (exp_ov && rif.out_ready) begin
          check($sformatf("r%0d_diff", g), 32'(rif.difference), 32'(ed));
          check($sformatf("r%0d_bout", g), 32'(rif.borrow_out), 32'(ebo));
`ifdef SERIAL_SUB_SIGNED_OVF_EN
          check($sformatf("r%0d_ovf", g), 32'(rif.overflow), 32'(eovf));
`endif
          pending = 1'b0;
          done_ops++;
        end
        if (rif.in_valid && mrdy) begin
          full     = {1'b0, rif.a} - {1'b0, rif.b} - (W+1)'(rif.borrow_in);
          ed       = full[W-1:0];
          ebo      = full[W];
          eovf     = (rif.a[W-1] != rif.b[W-1]) && (ed[W-1] != rif.a[W-1]);
          pending  = 1'b1;
          acc_iter = iter;
        end
        iter++;
      end
      check($sformatf("r%0d_ops", g), done_ops, NOPS);
      rif.in_valid = 1'b0;
      done_cnt++;
    end
  end
endmodule
